// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-decode helpers for the load/store
// memory stage.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int BE_W = 4;

    // funct3[1:0] encodes the access size for every legal load and store
    function automatic logic [BE_W-1:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lsu_byte_en = 4'b0001 << off;
            2'b01:   lsu_byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: lsu_byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

    function automatic logic lsu_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lsu_aligned = 1'b1;
            2'b01:   lsu_aligned = ~off[0];
            default: lsu_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-bus interface between the memory stage (master) and the SRAM/bus (slave).
interface lsu_mem_stage_if #(parameter int XLEN = 32);
    import lsu_pkg::*;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [BE_W-1:0] bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Load formatter: picks the addressed byte/halfword lane out of the bus word and
// sign- or zero-extends it for writeback.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_lane;

    // Halfword offsets are always even, so one byte-granular shift serves every size
    assign w_lane = i_rdata >> {i_off, 3'b000};

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: o_data = w_lane;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store responder: launches one bus access per instruction,
// stalls the pipeline while it is outstanding and reports faults.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_stall,
    output logic              o_load_valid,
    output logic [XLEN-1:0]   o_load_data,
    output logic              o_fault,
    lsu_mem_stage_if.master   io_bus
);

    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lsu_state_t      r_state;
    logic            r_bus_req;
    logic            r_bus_we;
    logic [XLEN-1:0] r_bus_addr;
    logic [BE_W-1:0] r_bus_be;
    logic [XLEN-1:0] r_bus_wdata;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;
    logic [XLEN-1:0] r_load_data;

    logic            w_access;
    logic            w_ok;
    logic            w_start;
    logic            w_illegal;
    logic            w_expire;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_load_fmt;

    // Gating with rst_n keeps stall/fault low while reset is held
    assign w_access  = rst_n && (r_state == IDLE) && i_mem_valid && (i_mem_read || i_mem_write);
    assign w_ok      = (i_mem_read ^ i_mem_write)
                       && lsu_legal(i_mem_read, i_funct3)
                       && lsu_aligned(i_funct3, i_addr[1:0]);
    assign w_start   = w_access && w_ok;
    assign w_illegal = w_access && !w_ok;
    assign w_expire  = (TIMEOUT != 0) && (r_cnt == CW'(TO_LAST));

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_wdata_rep = {(XLEN/8){i_wdata[7:0]}};
            2'b01:   w_wdata_rep = {(XLEN/16){i_wdata[15:0]}};
            default: w_wdata_rep = i_wdata;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .i_rdata  (io_bus.bus_rdata),
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .o_data   (w_load_fmt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= BUSY;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_write;
                        r_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        r_bus_be    <= lsu_byte_en(i_funct3, i_addr[1:0]);
                        r_bus_wdata <= w_wdata_rep;
                        r_funct3    <= i_funct3;
                        r_off       <= i_addr[1:0];
                        r_cnt       <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                // An ack in the expiry cycle still completes the access normally
                BUSY: begin
                    if (io_bus.bus_ack) begin
                        r_state   <= DONE;
                        r_bus_req <= 1'b0;
                        if (!r_bus_we)
                            r_load_data <= w_load_fmt;
                    end else if (w_expire) begin
                        r_state   <= DONE;
                        r_bus_req <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall      = w_start || (r_state == BUSY);
    assign o_load_valid = (r_state == DONE) && !r_bus_we && !r_timeout;
    assign o_fault      = w_illegal || ((r_state == DONE) && r_timeout);
    assign o_load_data  = r_load_data;

    assign io_bus.bus_req   = r_bus_req;
    assign io_bus.bus_we    = r_bus_we;
    assign io_bus.bus_addr  = r_bus_addr;
    assign io_bus.bus_be    = r_bus_be;
    assign io_bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, loads with extension, illegal
// accesses, bus timeout and reset in the middle of an access.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        memValid = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic        loadValid;
    logic [31:0] loadData;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_stage_if #(.XLEN(XLEN)) bus ();

    lsu_mem_stage #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mem_valid  (memValid),
        .i_mem_read   (memRead),
        .i_mem_write  (memWrite),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_load_valid (loadValid),
        .o_load_data  (loadData),
        .o_fault      (fault),
        .io_bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        memValid = v;
        memRead  = rd;
        memWrite = wr;
        funct3   = f3;
        addr     = a;
        wdata    = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Load with a one-cycle bus response, then one idle cycle to check the hold
    task automatic loadAccess(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] rdata, input logic [31:0] expBusAddr,
                              input logic [3:0] expBe, input logic [31:0] expData);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
        @(negedge clk);
        checkOutput({tag, " stall c0"}, stall, 1);
        nextCycle();
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = rdata;
        @(negedge clk);
        checkOutput({tag, " bus_req c1"}, bus.bus_req, 1);
        checkOutput({tag, " bus_addr"}, bus.bus_addr, expBusAddr);
        checkOutput({tag, " bus_be"}, bus.bus_be, expBe);
        checkOutput({tag, " bus_we"}, bus.bus_we, 0);
        nextCycle();
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        @(negedge clk);
        checkOutput({tag, " load_valid done"}, loadValid, 1);
        checkOutput({tag, " load_data"}, loadData, expData);
        checkOutput({tag, " stall done"}, stall, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput({tag, " load_valid idle"}, loadValid, 0);
        checkOutput({tag, " load_data hold"}, loadData, expData);
    endtask

    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst stall", stall, 0);
        checkOutput("rst bus_req", bus.bus_req, 0);
        checkOutput("rst bus_we", bus.bus_we, 0);
        checkOutput("rst bus_addr", bus.bus_addr, 0);
        checkOutput("rst bus_be", bus.bus_be, 0);
        checkOutput("rst bus_wdata", bus.bus_wdata, 0);
        checkOutput("rst load_data", loadData, 0);
        checkOutput("rst load_valid", loadValid, 0);
        checkOutput("rst fault", fault, 0);
        nextCycle();
        rst_n = 1'b1;

        // SW 0x100, ack two cycles after bus_req rises
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("sw stall c0", stall, 1);
        checkOutput("sw bus_req c0", bus.bus_req, 0);
        checkOutput("sw fault c0", fault, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("sw bus_req c1", bus.bus_req, 1);
        checkOutput("sw bus_addr", bus.bus_addr, 32'h100);
        checkOutput("sw bus_be", bus.bus_be, 4'b1111);
        checkOutput("sw bus_we", bus.bus_we, 1);
        checkOutput("sw bus_wdata", bus.bus_wdata, 32'hDEADBEEF);
        checkOutput("sw stall c1", stall, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("sw bus_req c2", bus.bus_req, 1);
        checkOutput("sw stall c2", stall, 1);
        nextCycle();
        bus.bus_ack = 1'b1;
        @(negedge clk);
        checkOutput("sw stall c3", stall, 1);
        checkOutput("sw load_valid c3", loadValid, 0);
        nextCycle();
        bus.bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("sw stall done", stall, 0);
        checkOutput("sw bus_req done", bus.bus_req, 0);
        checkOutput("sw load_valid done", loadValid, 0);
        checkOutput("sw fault done", fault, 0);
        checkOutput("sw load_data untouched", loadData, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("sw stall idle", stall, 0);

        // Byte loads with sign and zero extension from the top lane
        loadAccess("lb", F3_B, 32'h203, 32'h80123456, 32'h200, 4'b1000, 32'hFFFFFF80);
        loadAccess("lbu", F3_BU, 32'h203, 32'h80123456, 32'h200, 4'b1000, 32'h00000080);

        // SH to the upper halfword
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, F3_H, 32'h102, 32'h00001234);
        @(negedge clk);
        checkOutput("sh stall c0", stall, 1);
        nextCycle();
        bus.bus_ack = 1'b1;
        @(negedge clk);
        checkOutput("sh bus_addr", bus.bus_addr, 32'h100);
        checkOutput("sh bus_be", bus.bus_be, 4'b1100);
        checkOutput("sh bus_wdata", bus.bus_wdata, 32'h12341234);
        checkOutput("sh bus_we", bus.bus_we, 1);
        nextCycle();
        bus.bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("sh load_valid done", loadValid, 0);
        checkOutput("sh load_data hold", loadData, 32'h00000080);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        loadAccess("lhu", F3_HU, 32'h102, 32'hBEEF0000, 32'h100, 4'b1100, 32'h0000BEEF);

        // Misaligned, illegal funct3 and read+write together
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h101, 32'h0);
        @(negedge clk);
        checkOutput("lw misaligned fault", fault, 1);
        checkOutput("lw misaligned stall", stall, 0);
        checkOutput("lw misaligned bus_req", bus.bus_req, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("f3=3 fault", fault, 1);
        checkOutput("f3=3 stall", stall, 0);
        checkOutput("f3=3 bus_req", bus.bus_req, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, F3_W, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("rd+wr fault", fault, 1);
        checkOutput("rd+wr stall", stall, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("post-illegal fault", fault, 0);
        checkOutput("post-illegal bus_req", bus.bus_req, 0);

        // Timeout: no ack, bus_req for exactly 4 cycles
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h40, 32'h0);
        @(negedge clk);
        checkOutput("to stall c0", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("to bus_req c%0d", i), bus.bus_req, 1);
            checkOutput($sformatf("to stall c%0d", i), stall, 1);
        end
        nextCycle();
        @(negedge clk);
        checkOutput("to bus_req done", bus.bus_req, 0);
        checkOutput("to fault done", fault, 1);
        checkOutput("to load_valid done", loadValid, 0);
        checkOutput("to stall done", stall, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("to fault idle", fault, 0);
        checkOutput("to load_data hold", loadData, 32'h0000BEEF);

        // Reset in the middle of an access, then a stray ack
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, F3_W, 32'h80, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("rb bus_req busy", bus.bus_req, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rb bus_req in reset", bus.bus_req, 0);
        checkOutput("rb stall in reset", stall, 0);
        checkOutput("rb load_data in reset", loadData, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        nextCycle();
        rst_n = 1'b1;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("rb bus_req stray ack", bus.bus_req, 0);
        checkOutput("rb stall stray ack", stall, 0);
        nextCycle();
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        @(negedge clk);
        checkOutput("rb load_valid stray ack", loadValid, 0);
        checkOutput("rb load_data stray ack", loadData, 0);

        loadAccess("lw fresh", F3_W, 32'h80, 32'h11223344, 32'h80, 4'b1111, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
